// File: rtl/fence_seq_pkg.sv
// Shared types for the fence sequencer: FSM states, operation codes and timeout counter width.
package fence_seq_pkg;

    localparam int FENCE_TIMEOUT_W = 16;

    typedef enum logic [2:0] {IDLE, DFLUSH, DCLEAR, ICLEAR, DONE} fence_state_t;

    typedef enum logic [1:0] {FENCE, FENCE_I, FLUSH_ALL} fence_op_t;

    // Request priority: flush-all beats FENCE.I beats plain FENCE (the fallback).
    function automatic fence_op_t select_op(input logic fence_i, input logic flush_all);
        if (flush_all) return FLUSH_ALL;
        if (fence_i) return FENCE_I;
        return FENCE;
    endfunction

endpackage

// File: rtl/fence_sequencer.sv
// Sequences dcache write-back / invalidate and icache invalidate for FENCE, FENCE.I and flush-all.
// Build macro FENCE_SEQ_TIMEOUT_EN adds a per-step wait counter that aborts with fence_error.
module fence_sequencer
    import fence_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic CLK,
    input  logic nRST,
    input  logic fence_req,
    input  logic fence_i_req,
    input  logic flush_all_req,
    output logic fence_busy,
    output logic fence_done,
    output logic fence_error,
    output logic dcache_flush,
    output logic dcache_clear,
    output logic icache_clear,
    output logic icache_flush,
    input  logic dflush_done,
    input  logic dclear_done,
    input  logic iclear_done,
    input  logic iflush_done
);

    localparam logic [FENCE_TIMEOUT_W-1:0] TIMEOUT_LAST = FENCE_TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    fence_state_t state, state_next;
    fence_op_t    op, op_next;
    logic         step_done;
    logic         abort;
    logic         unused_sig;

    // Only the done belonging to the current step counts; stale dones for other steps are ignored.
    always_comb begin
        case (state)
            DFLUSH:  step_done = dflush_done;
            DCLEAR:  step_done = dclear_done;
            ICLEAR:  step_done = iclear_done;
            default: step_done = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: defaults first so every path assigns each variable; a missing branch would otherwise infer a latch.
        state_next = state;
        op_next    = op;
        case (state)
            IDLE: begin
                if (fence_req || fence_i_req || flush_all_req) begin
                    op_next    = select_op(fence_i_req, flush_all_req);
                    state_next = DFLUSH;
                end
            end
            DFLUSH: begin
                if (step_done) begin
                    case (op)
                        FLUSH_ALL: state_next = DCLEAR;
                        FENCE_I:   state_next = ICLEAR;
                        default:   state_next = DONE;
                    endcase
                end
            end
            DCLEAR:  if (step_done) state_next = ICLEAR;
            ICLEAR:  if (step_done) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            op    <= FENCE;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state <= state_next;
            op    <= op_next;
        end
    end

    // Commands are a pure decode of the state register, so exactly one is high per wait state.
    assign fence_busy   = (state != IDLE);
    assign fence_done   = (state == DONE);
    assign dcache_flush = (state == DFLUSH);
    assign dcache_clear = (state == DCLEAR);
    assign icache_clear = (state == ICLEAR);
    assign icache_flush = 1'b0;

`ifdef FENCE_SEQ_TIMEOUT_EN
    logic [FENCE_TIMEOUT_W-1:0] wait_cnt;
    logic                       waiting;
    logic                       error_q;

    assign waiting = (state == DFLUSH) || (state == DCLEAR) || (state == ICLEAR);
    assign abort   = waiting && !step_done && (wait_cnt == TIMEOUT_LAST);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wait_cnt <= '0;
            error_q  <= 1'b0;
        end else begin
            error_q <= abort;
            if (state_next != state) wait_cnt <= '0;
            else if (waiting)        wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign fence_error = error_q;
    assign unused_sig  = iflush_done;
`else
    assign abort       = 1'b0;
    assign fence_error = 1'b0;
    assign unused_sig  = ^{iflush_done, TIMEOUT_LAST};
`endif

endmodule

// File: tb/tb_fence_sequencer.sv
// Self-checking bench for fence_sequencer: directed scenarios plus random traffic against a step-list model.
// Define FENCE_SEQ_TIMEOUT_EN for both bench and RTL to exercise the timeout abort.
module tb_fence_sequencer;

    localparam int TIMEOUT = 8;
`ifdef FENCE_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int NEVER = 1000000;

    logic CLK, nRST;
    logic fence_req, fence_i_req, flush_all_req;
    logic fence_busy, fence_done, fence_error;
    logic dcache_flush, dcache_clear, icache_clear, icache_flush;
    logic dflush_done, dclear_done, iclear_done, iflush_done;

    fence_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .CLK(CLK), .nRST(nRST),
        .fence_req(fence_req), .fence_i_req(fence_i_req), .flush_all_req(flush_all_req),
        .fence_busy(fence_busy), .fence_done(fence_done), .fence_error(fence_error),
        .dcache_flush(dcache_flush), .dcache_clear(dcache_clear),
        .icache_clear(icache_clear), .icache_flush(icache_flush),
        .dflush_done(dflush_done), .dclear_done(dclear_done),
        .iclear_done(iclear_done), .iflush_done(iflush_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: an accepted operation becomes a list of cache steps (1=dflush, 2=dclear, 3=iclear)
    // that is consumed one matching done at a time, followed by a single done cycle.
    int m_steps[$];
    bit m_in_done, m_err;
    int m_wait;

    task automatic model_reset();
        m_steps.delete();
        m_in_done = 1'b0;
        m_err     = 1'b0;
        m_wait    = 0;
    endtask

    // Packing: {busy, done, error, dcache_flush, dcache_clear, icache_clear, icache_flush}
    function automatic logic [6:0] model_outputs();
        int cmd;
        cmd = (m_steps.size() != 0) ? m_steps[0] : 0;
        return {((m_steps.size() != 0) || m_in_done), m_in_done, m_err,
                (cmd == 1), (cmd == 2), (cmd == 3), 1'b0};
    endfunction

    task automatic model_update(input bit fr, input bit fir, input bit far,
                                input bit dfd, input bit dcd, input bit icd);
        bit got;
        m_err = 1'b0;
        if (m_in_done) begin
            m_in_done = 1'b0;
        end else if (m_steps.size() != 0) begin
            got = (m_steps[0] == 1 && dfd) || (m_steps[0] == 2 && dcd) || (m_steps[0] == 3 && icd);
            if (got) begin
                void'(m_steps.pop_front());
                m_wait = 0;
                if (m_steps.size() == 0) m_in_done = 1'b1;
            end else if (TO_EN && m_wait == TIMEOUT - 1) begin
                m_steps.delete();
                m_err  = 1'b1;
                m_wait = 0;
            end else begin
                m_wait++;
            end
        end else if (far) begin
            m_steps = '{1, 2, 3};
            m_wait  = 0;
        end else if (fir) begin
            m_steps = '{1, 3};
            m_wait  = 0;
        end else if (fr) begin
            m_steps = '{1};
            m_wait  = 0;
        end
    endtask

    // Stimulus state: held requests, responder delay, observation counters
    bit       req_fr, req_fir, req_far;
    bit [2:0] drop_mask = 3'b111;   // {far, fir, fr} dropped on fence_done/fence_error
    bit       random_mode, stale_ic, block_dc;
    int       done_delay;
    int       cnt_df, cnt_dc, cnt_ic;
    int       tick_no;
    int       o_df, o_dc, o_ic, o_done, o_err;
    int       f_df, f_ic, f_done, f_err;
    int       req_t;

    task automatic clear_obs();
        o_df = 0; o_dc = 0; o_ic = 0; o_done = 0; o_err = 0;
        f_df = -1; f_ic = -1; f_done = -1; f_err = -1;
    endtask

    function automatic logic [6:0] dut_outputs();
        return {fence_busy, fence_done, fence_error, dcache_flush, dcache_clear, icache_clear, icache_flush};
    endfunction

    // One cycle: sample at negedge, compare with model, then drive next inputs and advance the model.
    task automatic tick();
        bit dfd, dcd, icd;
        @(negedge CLK);
        tick_no++;
        check("outs", {25'd0, dut_outputs()}, {25'd0, model_outputs()});

        o_df += int'(dcache_flush); o_dc += int'(dcache_clear); o_ic += int'(icache_clear);
        o_done += int'(fence_done); o_err += int'(fence_error);
        if (dcache_flush && f_df < 0) f_df = tick_no;
        if (icache_clear && f_ic < 0) f_ic = tick_no;
        if (fence_done && f_done < 0) f_done = tick_no;
        if (fence_error && f_err < 0) f_err = tick_no;

        if (fence_done || fence_error) begin
            if (drop_mask[0]) req_fr  = 1'b0;
            if (drop_mask[1]) req_fir = 1'b0;
            if (drop_mask[2]) req_far = 1'b0;
        end

        if (random_mode) begin
            if (!(req_fr || req_fir || req_far) && $urandom_range(0, 3) == 0)
                {req_far, req_fir, req_fr} = 3'($urandom_range(1, 7));
            dfd = ($urandom_range(0, 2) == 0);
            dcd = ($urandom_range(0, 2) == 0);
            icd = ($urandom_range(0, 2) == 0);
            iflush_done = 1'($urandom_range(0, 1));
        end else begin
            cnt_df = dcache_flush ? cnt_df + 1 : 0;
            cnt_dc = dcache_clear ? cnt_dc + 1 : 0;
            cnt_ic = icache_clear ? cnt_ic + 1 : 0;
            dfd = dcache_flush && cnt_df > done_delay;
            dcd = dcache_clear && cnt_dc > done_delay && !block_dc;
            icd = (icache_clear && cnt_ic > done_delay) || (stale_ic && dcache_flush);
            iflush_done = 1'b0;
        end

        fence_req = req_fr; fence_i_req = req_fir; flush_all_req = req_far;
        dflush_done = dfd; dclear_done = dcd; iclear_done = icd;
        model_update(req_fr, req_fir, req_far, dfd, dcd, icd);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic start(input bit fr, input bit fir, input bit far);
        req_fr = fr; req_fir = fir; req_far = far;
        req_t  = tick_no + 1;
        clear_obs();
    endtask

    initial begin
        nRST = 1'b0;
        {fence_req, fence_i_req, flush_all_req} = '0;
        {dflush_done, dclear_done, iclear_done, iflush_done} = '0;
        model_reset();
        clear_obs();
        done_delay = 0;
        #3;
        check("reset_outs", {25'd0, dut_outputs()}, 32'd0);
        run(2);
        nRST = 1'b1;
        run(2);

        // FENCE, dflush_done two cycles after dcache_flush rises
        done_delay = 2;
        start(1'b1, 1'b0, 1'b0);
        run(8);
        check("a_dflush_cycles", o_df, 3);
        check("a_done_pulses", o_done, 1);
        check("a_iclear_cycles", o_ic, 0);
        check("a_dflush_start", f_df - req_t, 1);

        // Minimum FENCE latency with immediate done: 3 cycles including the request cycle
        done_delay = 0;
        start(1'b1, 1'b0, 1'b0);
        run(5);
        check("fence_min_latency", f_done - req_t + 1, 3);

        // FENCE.I with immediate dones: dflush then iclear, 4 cycles
        start(1'b0, 1'b1, 1'b0);
        run(6);
        check("b_dflush_first", f_df - req_t, 1);
        check("b_iclear_second", f_ic - req_t, 2);
        check("b_latency", f_done - req_t + 1, 4);
        check("b_dclear_cycles", o_dc, 0);

        // flush_all and fence together: FLUSH_ALL wins, held fence is accepted right after DONE
        drop_mask = 3'b110;
        start(1'b1, 1'b0, 1'b1);
        run(5);
        check("c_latency", f_done - req_t + 1, 5);
        check("c_dflush_cycles", o_df, 1);
        check("c_dclear_cycles", o_dc, 1);
        check("c_iclear_cycles", o_ic, 1);
        drop_mask = 3'b111;
        run(5);
        check("c_back_to_back_dflush", o_df, 2);
        check("c_back_to_back_done", o_done, 2);

        // Stale iclear_done during DFLUSH of FENCE.I must not skip ICLEAR's own wait
        done_delay = 2;
        stale_ic   = 1'b1;
        start(1'b0, 1'b1, 1'b0);
        run(10);
        stale_ic = 1'b0;
        check("d_dflush_cycles", o_df, 3);
        check("d_iclear_cycles", o_ic, 3);
        check("d_iclear_entry", f_ic - req_t, 4);
        check("d_done_pulses", o_done, 1);

        // Asynchronous reset in the middle of DCLEAR
        done_delay = 0;
        block_dc   = 1'b1;
        start(1'b0, 1'b0, 1'b1);
        run(4);
        @(posedge CLK);
        #2;
        check("e_in_dclear", {31'd0, dcache_clear}, 32'd1);
        nRST = 1'b0;
        #1;
        check("e_reset_async", {25'd0, dut_outputs()}, 32'd0);
        model_reset();
        req_far  = 1'b0;
        block_dc = 1'b0;
        run(1);
        start(1'b1, 1'b0, 1'b0);
        run(1);
        nRST = 1'b1;
        run(5);
        check("e_after_reset_done", o_done, 1);
        check("e_after_reset_latency", f_done - req_t + 1, 3);

`ifdef FENCE_SEQ_TIMEOUT_EN
        // dflush_done never returns: abort after TIMEOUT cycles in DFLUSH
        done_delay = NEVER;
        start(1'b1, 1'b0, 1'b0);
        run(12);
        check("f_dflush_cycles", o_df, TIMEOUT);
        check("f_error_offset", f_err - f_df, TIMEOUT);
        check("f_error_pulses", o_err, 1);
        check("f_done_pulses", o_done, 0);
        check("f_idle_after", {31'd0, fence_busy}, 32'd0);
`else
        // Without the timeout the sequencer waits indefinitely for its done
        done_delay = NEVER;
        start(1'b1, 1'b0, 1'b0);
        run(21);
        check("f_wait_dflush_cycles", o_df, 20);
        check("f_wait_error_pulses", o_err, 0);
        done_delay = 0;
        run(3);
        check("f_wait_done_pulses", o_done, 1);
`endif

        // Random traffic with random and stale dones
        done_delay = 0;
        clear_obs();
        random_mode = 1'b1;
        run(3000);
        random_mode = 1'b0;
        run(12);
        check("rand_drained_busy", {31'd0, fence_busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
